// File: rtl/snn_noc_pkg.sv
// snn_noc_pkg: shared address width, spike address type and dispatcher state encoding
package snn_noc_pkg;
    localparam int ADDRESS_BITS = 12;
    typedef logic [ADDRESS_BITS-1:0] spike_addr_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } disp_state_e;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/spike_priority_encoder.sv
// spike_priority_encoder: lowest set index of a flag vector plus an any-set flag
//   in_vec  in   WIDTH   flags to search
//   idx     out  IDX_W   index of the lowest set flag (0 when none set)
//   any     out  1       at least one flag set
module spike_priority_encoder #(
    parameter int WIDTH = 10,
    parameter int IDX_W = snn_noc_pkg::idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (in_vec[i]) idx = IDX_W'(i);
    end
    assign any = |in_vec;
endmodule

// File: rtl/spike_dispatcher.sv
// spike_dispatcher: serialises one cluster's fired-neuron flags as source addresses on valid/ready
//   CLK, RST        clock, synchronous active-high reset
//   spike_vector    fired flags, latched on an accepted timestep_done
//   timestep_done   pulse starting a dispatch (ignored and flagged as overrun while busy)
//   base_address    address of neuron 0, latched with spike_vector
//   source_address  address offered, spike_valid qualifies it, spike_ready accepts it
//   busy            dispatch in progress
//   dispatch_done   one-cycle pulse once every latched spike has been sent
//   overrun         sticky: timestep_done seen while busy
//   spike_count     popcount of the latched vector, only when SPIKE_DISPATCH_COUNT_EN is defined
module spike_dispatcher #(
    parameter int NUMBER_OF_UNITS = 10,
    parameter int ADDRESS_BITS    = snn_noc_pkg::ADDRESS_BITS,
    localparam int IDX_W          = snn_noc_pkg::idx_width(NUMBER_OF_UNITS),
    localparam int CNT_W          = $clog2(NUMBER_OF_UNITS + 1)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUMBER_OF_UNITS-1:0] spike_vector,
    input  logic                       timestep_done,
    input  logic [ADDRESS_BITS-1:0]    base_address,
    output logic [ADDRESS_BITS-1:0]    source_address,
    output logic                       spike_valid,
    input  logic                       spike_ready,
    output logic                       busy,
    output logic                       dispatch_done,
    output logic                       overrun
`ifdef SPIKE_DISPATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]           spike_count
`endif
);
    import snn_noc_pkg::*;

    disp_state_e                state_q, state_d;
    logic [NUMBER_OF_UNITS-1:0] pending_q, pending_d, pend_nxt;
    logic [ADDRESS_BITS-1:0]    base_q, base_d, src_q, src_d;
    logic                       valid_q, valid_d, done_q, done_d, ovr_q, ovr_d, busy_q, busy_d;
    logic [IDX_W-1:0]           nxt_idx;
    logic                       nxt_any, accept;

    assign accept   = valid_q && spike_ready;
    // Drop the accepted (lowest) bit ahead of the edge so the next address is registered in time
    assign pend_nxt = accept ? (pending_q & (pending_q - NUMBER_OF_UNITS'(1))) : pending_q;

    spike_priority_encoder #(.WIDTH(NUMBER_OF_UNITS), .IDX_W(IDX_W)) u_enc (
        .in_vec (pend_nxt),
        .idx    (nxt_idx),
        .any    (nxt_any)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        base_d    = base_q;
        src_d     = src_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        ovr_d     = ovr_q | (timestep_done && state_q != IDLE);
        case (state_q)
            IDLE: if (timestep_done) begin
                pending_d = spike_vector;
                base_d    = base_address;
                state_d   = (|spike_vector) ? SEND : DONE;
                done_d    = ~|spike_vector;
            end
            SEND: begin
                pending_d = pend_nxt;
                valid_d   = nxt_any;
                src_d     = base_q + ADDRESS_BITS'(nxt_idx);
                state_d   = nxt_any ? SEND : DONE;
                done_d    = ~nxt_any;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            pending_q <= '0;
            base_q    <= '0;
            src_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            base_q    <= base_d;
            src_q     <= src_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign source_address = src_q;
    assign spike_valid    = valid_q;
    assign busy           = busy_q;
    assign dispatch_done  = done_q;
    assign overrun        = ovr_q;

`ifdef SPIKE_DISPATCH_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d, pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUMBER_OF_UNITS; i++) pop = pop + CNT_W'(spike_vector[i]);
        count_d = (state_q == IDLE && timestep_done) ? pop : count_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) count_q <= '0;
        else     count_q <= count_d;
    end

    assign spike_count = count_q;
`endif
endmodule
